// File: rtl/ad_pnmon_par.sv
// Parallel PN sequence monitor: self-seeds from the received stream, locks after
// a run of correct words, then checks each word against its own generator.
module ad_pnmon_par #(
    parameter logic [31:0] POL_MASK      = 32'h000000C0,
    parameter int          POL_W         = 7,
    parameter int          DW            = 16,
    parameter int          OOS_THRESHOLD = 16,
    parameter int          ERRCNT_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_in_valid,
    input  logic [DW-1:0]       data_in,
    input  logic                err_count_clr,
    output logic                pn_oos,
    output logic                pn_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int PRIME_N = (POL_W + DW - 1) / DW;
    localparam int PW      = $clog2(PRIME_N + 1);
    localparam int CW      = $clog2(OOS_THRESHOLD + 1);
    localparam bit ZERO_CHK = (DW >= POL_W);

    localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_N);
    localparam logic [CW-1:0] THR_LAST   = CW'(OOS_THRESHOLD - 1);

    typedef enum logic {
        ST_OOS,
        ST_SYNC
    } state_t;

    // Next DW bits of the recursion, MSB (oldest) first, seeded by the newest POL_W bits.
    function automatic logic [DW-1:0] pn_predict(input logic [POL_W-1:0] seed);
        logic [POL_W-1:0] win;
        logic             fb;
        logic [DW-1:0]    word;
        win  = seed;
        word = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = 1'b0;
            for (int m = 1; m <= POL_W; m++) begin
                fb = fb ^ (POL_MASK[m] & win[m-1]);
            end
            word[i] = fb;
            win     = (win << 1) | POL_W'(fb);
        end
        return word;
    endfunction

    state_t              state_q, state_d;
    logic                in_valid_q, in_valid_d;
    logic [DW-1:0]       in_data_q, in_data_d;
    logic [POL_W-1:0]    h_q, h_d;
    logic [PW-1:0]       prime_cnt_q, prime_cnt_d;
    logic [CW-1:0]       match_cnt_q, match_cnt_d;
    logic [CW-1:0]       mis_cnt_q, mis_cnt_d;
    logic                pn_err_q, pn_err_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    logic [DW-1:0]       pn_exp;
    logic [POL_W-1:0]    h_from_data;
    logic [POL_W-1:0]    h_from_exp;
    logic                h_ready;
    logic                word_match;

    assign pn_exp     = pn_predict(h_q);
    assign h_ready    = (prime_cnt_q == PRIME_DONE);
    // An all-zero word never matches, so the monitor cannot lock onto the LFSR lock-up state.
    assign word_match = h_ready && (in_data_q == pn_exp) && !(ZERO_CHK && (in_data_q == '0));

    // Only the newest POL_W history bits seed the prediction, so only those are kept.
    generate
        if (DW >= POL_W) begin : g_hist_wide
            assign h_from_data = in_data_q[POL_W-1:0];
            assign h_from_exp  = pn_exp[POL_W-1:0];
        end else begin : g_hist_narrow
            assign h_from_data = {h_q[POL_W-DW-1:0], in_data_q};
            assign h_from_exp  = {h_q[POL_W-DW-1:0], pn_exp};
        end
    endgenerate

    // NOTE: every variable gets its hold/default value first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        in_valid_d  = data_in_valid;
        in_data_d   = data_in_valid ? data_in : in_data_q;
        h_d         = h_q;
        prime_cnt_d = prime_cnt_q;
        match_cnt_d = match_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        pn_err_d    = 1'b0;

        if (in_valid_q) begin
            if (!h_ready) begin
                prime_cnt_d = prime_cnt_q + PW'(1);
            end
            if (state_q == ST_OOS) begin
                h_d = h_from_data;
                if (word_match) begin
                    if (match_cnt_q == THR_LAST) begin
                        state_d     = ST_SYNC;
                        match_cnt_d = '0;
                        mis_cnt_d   = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + CW'(1);
                    end
                end else begin
                    match_cnt_d = '0;
                end
            end else begin
                // In sync the own generator drives the history, so a bad word cannot derail it.
                h_d = h_from_exp;
                if (!word_match) begin
                    pn_err_d = 1'b1;
                    if (mis_cnt_q == THR_LAST) begin
                        state_d     = ST_OOS;
                        match_cnt_d = '0;
                        mis_cnt_d   = '0;
                    end else begin
                        mis_cnt_d = mis_cnt_q + CW'(1);
                    end
                end else begin
                    mis_cnt_d = '0;
                end
            end
        end

        if (err_count_clr) begin
            err_count_d = '0;
        end else if (pn_err_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OOS;
            in_valid_q  <= 1'b0;
            prime_cnt_q <= '0;
            match_cnt_q <= '0;
            mis_cnt_q   <= '0;
            pn_err_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_valid_q  <= in_valid_d;
            prime_cnt_q <= prime_cnt_d;
            match_cnt_q <= match_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
            pn_err_q    <= pn_err_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: data and history registers carry no reset; in_valid_q and prime_cnt_q gate their use.
    always_ff @(posedge clk) begin
        in_data_q <= in_data_d;
        h_q       <= h_d;
    end

    assign pn_oos    = (state_q == ST_OOS);
    assign pn_err    = pn_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ad_pnmon_par.sv
// Self-checking bench for ad_pnmon_par: bit-serial PN7 source, word-level reference
// model feeding a scoreboard, a phase table and a few hand-written corner sequences.
module tb_ad_pnmon_par;

    localparam logic [31:0] POL_MASK = 32'h000000C0;
    localparam int MODE_CLEAN = 0;
    localparam int MODE_FLIP1 = 1;
    localparam int MODE_ZERO  = 2;
    localparam int MODE_FLIPE = 3;

    logic        clk;
    logic        reset;
    logic        data_in_valid;
    logic [15:0] data_in;
    logic        err_count_clr;
    logic        pn_oos, pn_err;
    logic [31:0] err_count;
    logic        pn_oos4, pn_err4;
    logic [3:0]  err_count4;

    ad_pnmon_par dut (
        .clk(clk), .reset(reset), .data_in_valid(data_in_valid), .data_in(data_in),
        .err_count_clr(err_count_clr), .pn_oos(pn_oos), .pn_err(pn_err), .err_count(err_count)
    );

    ad_pnmon_par #(.ERRCNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .data_in_valid(data_in_valid), .data_in(data_in),
        .err_count_clr(err_count_clr), .pn_oos(pn_oos4), .pn_err(pn_err4), .err_count(err_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        oos;
        logic        err;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;
    exp_t sb_q[$];

    // PN7 source, bit-serial: g[0] is the newest bit.
    logic [6:0] g = 7'h7F;
    task automatic next_pn(output logic [15:0] w);
        logic fb;
        for (int i = 15; i >= 0; i--) begin
            fb   = g[6] ^ g[5];
            w[i] = fb;
            g    = {g[5:0], fb};
        end
    endtask

    // Reference model of the monitor at word level.
    logic [6:0]  m_hist;
    bit          m_primed, m_oos, p_v;
    int          m_match, m_mis;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;
    logic [15:0] p_d;

    function automatic logic [15:0] m_predict(input logic [6:0] seed);
        logic [6:0]  s;
        logic [15:0] w;
        logic        fb;
        s = seed;
        for (int i = 15; i >= 0; i--) begin
            fb = 1'b0;
            for (int m = 1; m <= 7; m++) if (POL_MASK[m]) fb ^= s[m-1];
            w[i] = fb;
            s = {s[5:0], fb};
        end
        return w;
    endfunction

    task automatic model_reset();
        m_primed = 0; m_oos = 1; m_match = 0; m_mis = 0;
        m_cnt = 0; m_cnt4 = 0; p_v = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit clr, input bit rst);
        exp_t        e;
        bit          err, match;
        logic [15:0] xp;
        err = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (p_v) begin
                xp    = m_predict(m_hist);
                match = m_primed && (p_d == xp) && (p_d != 16'h0);
                m_primed = 1;
                if (m_oos) begin
                    m_hist = p_d[6:0];
                    if (match) begin
                        m_match++;
                        if (m_match == 16) begin m_oos = 0; m_match = 0; m_mis = 0; end
                    end else m_match = 0;
                end else begin
                    m_hist = xp[6:0];
                    if (!match) begin
                        err = 1;
                        m_mis++;
                        if (m_mis == 16) begin m_oos = 1; m_match = 0; m_mis = 0; end
                    end else m_mis = 0;
                end
            end
            if (clr) begin
                m_cnt = 0; m_cnt4 = 0;
            end else if (err) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 != 4'hF) m_cnt4++;
            end
            p_v = v;
            p_d = d;
        end
        e.oos = m_oos; e.err = err; e.cnt = m_cnt; e.cnt4 = m_cnt4;
        sb_q.push_back(e);
    endtask

    // One clock: compare what the DUT shows now, drive this cycle, predict, advance.
    task automatic cycle(input bit v, input logic [15:0] d, input bit clr, input bit rst);
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_oos", {31'b0, pn_oos}, {31'b0, e.oos});
            check("sb_err", {31'b0, pn_err}, {31'b0, e.err});
            check("sb_cnt", err_count, e.cnt);
            check("sb_cnt4", {28'b0, err_count4}, {28'b0, e.cnt4});
            check("sb_oos4", {31'b0, pn_oos4}, {31'b0, e.oos});
            if (pn_err === 1'b1) pulses++;
        end
        data_in_valid = v;
        data_in       = d;
        err_count_clr = clr;
        reset         = rst;
        model_step(v, d, clr, rst);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'($urandom), 0, 0);
    endtask

    task automatic run_words(input int n, input int mode, input bit rnd);
        logic [15:0] w;
        int          guard;
        for (int k = 0; k < n; k++) begin
            next_pn(w);
            if (mode == MODE_FLIP1 && k == 0) w[3] = ~w[3];
            if (mode == MODE_FLIPE && (k % 2) == 0) w[3] = ~w[3];
            if (mode == MODE_ZERO) w = 16'h0000;
            guard = 0;
            while (rnd && $urandom_range(0, 1) == 0 && guard < 20) begin
                idle(1);
                guard++;
            end
            cycle(1, w, 0, 0);
        end
    endtask

    typedef struct {
        bit rst;
        bit clr;
        int words;
        int mode;
        bit rnd;
        bit exp_oos;
        int exp_cnt;
        int exp_cnt4;
        int exp_pulses;
    } phase_t;
    phase_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        // rst clr words mode rnd | oos cnt cnt4 pulses
        tbl[0] = '{1, 0, 17, MODE_CLEAN, 0, 0,  0,  0,  0};
        tbl[1] = '{0, 0, 22, MODE_CLEAN, 0, 0,  0,  0,  0};
        tbl[2] = '{0, 0, 10, MODE_FLIP1, 0, 0,  1,  1,  1};
        tbl[3] = '{0, 1, 20, MODE_ZERO,  0, 1, 16, 15, 16};
        tbl[4] = '{1, 0, 40, MODE_CLEAN, 1, 0,  0,  0,  0};
        tbl[5] = '{0, 1, 40, MODE_FLIPE, 0, 0, 20, 15, 20};

        reset = 1; data_in_valid = 0; data_in = '0; err_count_clr = 0;
        model_reset();
        @(negedge clk);
        cycle(0, 16'h0, 0, 1);
        cycle(0, 16'h0, 0, 1);
        check("reset_oos", {31'b0, pn_oos}, 32'd1);
        check("reset_err", {31'b0, pn_err}, 32'd0);
        check("reset_cnt", err_count, 32'd0);

        for (int p = 0; p < 6; p++) begin
            if (tbl[p].rst) cycle(0, 16'h0, 0, 1);
            cycle(0, 16'($urandom), tbl[p].clr, 0);
            idle(1);
            pulses = 0;
            run_words(tbl[p].words, tbl[p].mode, tbl[p].rnd);
            idle(2);
            check($sformatf("ph%0d_oos", p), {31'b0, pn_oos}, {31'b0, tbl[p].exp_oos});
            check($sformatf("ph%0d_cnt", p), err_count, tbl[p].exp_cnt);
            check($sformatf("ph%0d_cnt4", p), {28'b0, err_count4}, tbl[p].exp_cnt4);
            check($sformatf("ph%0d_pulses", p), pulses, tbl[p].exp_pulses);
        end

        // Clear coinciding with an error update: count goes to 0, pulse still seen.
        next_pn(w); w[3] = ~w[3];
        cycle(1, w, 0, 0);
        next_pn(w);
        cycle(1, w, 1, 0);
        check("clr_err_pulse", {31'b0, pn_err}, 32'd1);
        check("clr_cnt", err_count, 32'd0);
        check("clr_cnt4", {28'b0, err_count4}, 32'd0);
        check("clr_oos", {31'b0, pn_oos}, 32'd0);
        idle(2);

        // Reset with errored words in flight: they are discarded.
        next_pn(w); w[3] = ~w[3];
        cycle(1, w, 0, 0);
        next_pn(w); w[3] = ~w[3];
        cycle(1, w, 0, 1);
        check("rst_oos", {31'b0, pn_oos}, 32'd1);
        check("rst_err", {31'b0, pn_err}, 32'd0);
        check("rst_cnt", err_count, 32'd0);
        idle(1);
        check("rst_err_next", {31'b0, pn_err}, 32'd0);
        run_words(16, MODE_CLEAN, 0);
        idle(2);
        check("relock_not_yet", {31'b0, pn_oos}, 32'd1);
        run_words(1, MODE_CLEAN, 0);
        idle(2);
        check("relock_done", {31'b0, pn_oos}, 32'd0);
        check("relock_cnt", err_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
